mstr0_rx: RTL and testbench
===========================

MSTR0_RX -- requirements
Module: mstr0_rx

Interface
REQ-001 SHALL have parameter DW, default 32, data word width.
REQ-002 SHALL have parameter DEPTH, default 4, buffer entries, power of two, >= 2.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port mstr0_data  input  DW  master-0 data word.
REQ-006 SHALL have port mstr0_data_valid  input  2  bit1 = source tag (0 processing, 1 fifo), bit0 = valid.
REQ-007 SHALL have port mstr0_ready  output  1  buffer not full; advisory only, sender does not stall.
REQ-008 SHALL have port flush  input  1  synchronous buffer clear request.
REQ-009 SHALL have port out_data  output  DW  head-of-buffer word.
REQ-010 SHALL have port out_src  output  1  source tag of out_data.
REQ-011 SHALL have port out_valid  output  1  head entry present.
REQ-012 SHALL have port out_ready  input  1  consumer accepts head.
REQ-013 SHALL have port overflow  output  1  sticky, word dropped while full.
REQ-014 SHALL have port busy  output  1  state != IDLE.
REQ-015 SHALL have ports cnt_src0 and cnt_src1  output  16 each  accepted-word counters (see Configuration).

Function
REQ-016 SHALL capture {mstr0_data_valid[1], mstr0_data} into the buffer in the same edge that bit0 is high and the buffer is not full, or is full with a pop in that cycle.
REQ-017 SHALL drop the word and set overflow when bit0 is high, the buffer is full and no pop occurs; overflow clears only on reset or flush.
REQ-018 SHALL pop the head on out_valid && out_ready; out_valid/out_data/out_src are registered from buffer head, first-word latency 1 cycle.
REQ-019 SHALL support simultaneous push and pop at any occupancy, including full, with occupancy unchanged.
REQ-020 SHALL wrap read/write pointers modulo DEPTH, with an extra pointer bit distinguishing full from empty.
REQ-021 SHALL hold out_data/out_src stable while out_valid && !out_ready.
REQ-022 SHALL implement FSM states IDLE (empty), ACTIVE (non-empty) and FLUSH.
REQ-023 SHALL transition IDLE->ACTIVE on push, ACTIVE->IDLE when the last entry pops with no push, and any state->FLUSH on flush.
REQ-024 SHALL spend exactly one cycle in FLUSH, emptying the buffer, clearing overflow and deasserting out_valid and mstr0_ready, then go to IDLE.
REQ-025 SHALL ignore input words and pops during FLUSH; flush has priority over push and pop in the same cycle.
REQ-026 SHALL deassert mstr0_ready when occupancy == DEPTH or state == FLUSH.

Reset
REQ-027 SHALL on rst clear pointers, occupancy, overflow and counters, and force the FSM to IDLE.
REQ-028 SHALL on rst drive out_valid=0, out_data=0, out_src=0, busy=0, mstr0_ready=1.
REQ-029 SHALL discard buffered data when rst asserts mid-transfer; no word is presented after release until a new push.

Configuration
REQ-030 SHALL, with macro MSTR0_RX_STATS_EN defined, increment cnt_src0 or cnt_src1 per accepted word by tag, saturating at 16'hFFFF, and clear both on flush.
REQ-031 SHALL, without MSTR0_RX_STATS_EN, tie cnt_src0 and cnt_src1 to 0 and instantiate no counter logic.

Structure
REQ-032 SHALL place FSM state enum (IDLE, ACTIVE, FLUSH), source-tag constants (SRC_PROC=0, SRC_FIFO=1) and counter width (16) in shared package mstr0_pkg.
REQ-033 SHALL implement the tagged buffer as sub-module mstr0_rx_buf; the FSM, flags and counters stay in mstr0_rx.

Verification
REQ-034 SHALL cover reset: pulse rst mid-stream with 2 words buffered -> out_valid=0, mstr0_ready=1, counters 0, no stale word afterwards.
REQ-035 SHALL cover ordering: push 0xA5A5_0001 (src 0) then 0x5A5A_0002 (src 1) with out_ready=1 -> both out in order with out_src 0 then 1, first word one cycle after push.
REQ-036 SHALL cover full/overflow: out_ready=0, push 5 words at DEPTH=4 -> mstr0_ready=0 after 4th, 5th dropped, overflow=1, first 4 drain intact.
REQ-037 SHALL cover full with simultaneous push/pop: full, out_ready=1, push 0xDEAD_BEEF -> accepted, overflow stays 0, occupancy stays 4.
REQ-038 SHALL cover flush: 3 words buffered, overflow=1, flush concurrent with push -> pushed word dropped, next cycle IDLE, out_valid=0, overflow=0.
REQ-039 SHALL cover stats with MSTR0_RX_STATS_EN: 3 src-0 and 2 src-1 accepted words, 1 dropped -> cnt_src0=3, cnt_src1=2.

Source files
------------

// File: rtl/mstr0_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mstr0_pkg
// Purpose : Shared types and constants for the master-0 receive path.
//           FSM state encoding, source-tag values and statistics counter width.
// Rev     : 1.0  initial release
// ============================================================================
package mstr0_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,   // buffer empty
        ACTIVE = 2'd1,   // buffer holds at least one entry
        FLUSH  = 2'd2    // one-cycle clear
    } state_t;

    localparam logic SRC_PROC = 1'b0;
    localparam logic SRC_FIFO = 1'b1;

    localparam int CNT_W = 16;

    // Saturating increment for the per-source statistics counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mstr0_rx_if.sv
`default_nettype none
// ============================================================================
// Module  : mstr0_rx_if
// Purpose : Bundles the master-0 input port, the consumer port and the
//           status outputs of mstr0_rx.
// Ports   : slave  - receiver side (mstr0_rx)
//           master - sender/consumer side (environment)
// Params  : DW - data word width
// Rev     : 1.0  initial release
// ============================================================================
interface mstr0_rx_if #(
    parameter int DW = 32
);
    logic [DW-1:0]                 mstr0_data;
    logic [1:0]                    mstr0_data_valid;  // [1]=tag, [0]=valid
    logic                          mstr0_ready;
    logic                          flush;
    logic [DW-1:0]                 out_data;
    logic                          out_src;
    logic                          out_valid;
    logic                          out_ready;
    logic                          overflow;
    logic                          busy;
    logic [mstr0_pkg::CNT_W-1:0]   cnt_src0;
    logic [mstr0_pkg::CNT_W-1:0]   cnt_src1;

    modport slave (
        input  mstr0_data, mstr0_data_valid, flush, out_ready,
        output mstr0_ready, out_data, out_src, out_valid,
               overflow, busy, cnt_src0, cnt_src1
    );

    modport master (
        output mstr0_data, mstr0_data_valid, flush, out_ready,
        input  mstr0_ready, out_data, out_src, out_valid,
               overflow, busy, cnt_src0, cnt_src1
    );
endinterface
`default_nettype wire

// File: rtl/mstr0_rx_buf.sv
`default_nettype none
// ============================================================================
// Module  : mstr0_rx_buf
// Purpose : Circular buffer holding tagged words. Pointers carry one extra
//           bit so that full (count == DEPTH) and empty (count == 0) differ.
// Ports   : clk, rst      - clock, async active-high reset
//           i_clr         - synchronous clear of both pointers
//           i_push/i_data - write one entry (caller guarantees room)
//           i_pop         - retire head entry (caller guarantees non-empty)
//           o_head        - entry at read pointer
//           o_count       - current occupancy, 0..DEPTH
// Params  : W     - entry width
//           DEPTH - entries, power of two, >= 2
// Rev     : 1.0  initial release
// ============================================================================
module mstr0_rx_buf #(
    parameter int W     = 33,
    parameter int DEPTH = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     i_clr,
    input  wire logic                     i_push,
    input  wire logic                     i_pop,
    input  wire logic [W-1:0]             i_data,
    output logic      [W-1:0]             o_head,
    output logic      [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: nothing is visible unless the pointers say so.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_count = r_wr_ptr - r_rd_ptr;

endmodule
`default_nettype wire

// File: rtl/mstr0_rx.sv
`default_nettype none
// ============================================================================
// Module  : mstr0_rx
// Purpose : Master-0 receive buffer. Captures tagged words from a sender that
//           never stalls, presents them in order to a ready/valid consumer,
//           flags drops while full and supports a one-cycle flush.
// Ports   : clk  - clock
//           rst  - async active-high reset
//           bus  - mstr0_rx_if.slave (input word, consumer port, status)
// Params  : DW    - data word width
//           DEPTH - buffer entries, power of two, >= 2
// Config  : MSTR0_RX_STATS_EN - enables per-source accepted-word counters;
//           when undefined cnt_src0/cnt_src1 are tied to zero.
// Rev     : 1.0  initial release
// ============================================================================
module mstr0_rx
    import mstr0_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input wire logic   clk,
    input wire logic   rst,
    mstr0_rx_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_overflow;
    logic [AW:0]   w_count;
    logic [DW:0]   w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_in_flush;
    logic          w_valid_in;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;

    assign w_in_flush = (r_state == FLUSH);
    assign w_full     = (w_count == (AW+1)'(DEPTH));
    assign w_empty    = (w_count == '0);

    // A flush request, or the FLUSH cycle itself, masks both ports.
    assign w_valid_in = bus.mstr0_data_valid[0] && !bus.flush && !w_in_flush;
    assign w_pop      = !w_empty && bus.out_ready && !bus.flush && !w_in_flush;
    // A pop in the same cycle frees the slot, so full still accepts.
    assign w_push     = w_valid_in && (!w_full || w_pop);
    assign w_drop     = w_valid_in && w_full && !w_pop;

    mstr0_rx_buf #(
        .W     (DW + 1),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (bus.flush),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({bus.mstr0_data_valid[1], bus.mstr0_data}),
        .o_head  (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.flush) begin
            w_state_nxt = FLUSH;
        end else begin
            case (r_state)
                IDLE:    if (w_push) w_state_nxt = ACTIVE;
                ACTIVE:  if (w_count == (AW+1)'(1) && w_pop && !w_push)
                             w_state_nxt = IDLE;
                FLUSH:   w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (bus.flush) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    // Head words come straight from registered storage; gating with valid
    // keeps the data/tag outputs at zero whenever nothing is presented.
    assign bus.out_valid   = !w_empty && !w_in_flush;
    assign bus.out_data    = bus.out_valid ? w_head[DW-1:0] : '0;
    assign bus.out_src     = bus.out_valid ? w_head[DW] : SRC_PROC;
    assign bus.mstr0_ready = !w_full && !w_in_flush;
    assign bus.busy        = (r_state != IDLE);
    assign bus.overflow    = r_overflow;

`ifdef MSTR0_RX_STATS_EN
    logic [CNT_W-1:0] r_cnt_src0;
    logic [CNT_W-1:0] r_cnt_src1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_src0 <= '0;
            r_cnt_src1 <= '0;
        end else if (bus.flush) begin
            r_cnt_src0 <= '0;
            r_cnt_src1 <= '0;
        end else if (w_push) begin
            if (bus.mstr0_data_valid[1] == SRC_FIFO)
                r_cnt_src1 <= sat_inc(r_cnt_src1);
            else
                r_cnt_src0 <= sat_inc(r_cnt_src0);
        end
    end

    assign bus.cnt_src0 = r_cnt_src0;
    assign bus.cnt_src1 = r_cnt_src1;
`else
    assign bus.cnt_src0 = '0;
    assign bus.cnt_src1 = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mstr0_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_mstr0_rx
// Purpose : Self-checking bench for mstr0_rx (DW=32, DEPTH=4). A queue-based
//           model predicts every output each cycle; a vector table and short
//           hand sequences cover ordering, full, overflow, flush, stats and
//           mid-stream reset; a random phase exercises the rest.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mstr0_rx;
    import mstr0_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
`ifdef MSTR0_RX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mstr0_rx_if #(.DW(DW)) bus ();

    mstr0_rx #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: ordered list of {tag, data}, plus flags.
    logic [DW:0] mq[$];
    bit          m_ovf;
    bit          m_flushing;
    int          m_c0;
    int          m_c1;

    typedef struct {
        bit          v;
        bit          s;
        logic [31:0] d;
        bit          ordy;
        bit          fl;
        bit          e_ov;
        logic [31:0] e_data;
        bit          e_src;
        bit          e_rdy;
        bit          e_busy;
        bit          e_ovf;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_ovf      = 1'b0;
        m_flushing = 1'b0;
        m_c0       = 0;
        m_c1       = 0;
    endtask

    task automatic check_model();
        logic [DW:0] h;
        bit          ev;
        ev = (mq.size() > 0);
        h  = ev ? mq[0] : '0;
        chk("m_out_valid", 32'(bus.out_valid),   32'(ev));
        chk("m_out_data",  bus.out_data,         h[DW-1:0]);
        chk("m_out_src",   32'(bus.out_src),     32'(h[DW]));
        chk("m_ready",     32'(bus.mstr0_ready), 32'(!m_flushing && mq.size() < DEPTH));
        chk("m_busy",      32'(bus.busy),        32'(m_flushing || ev));
        chk("m_overflow",  32'(bus.overflow),    32'(m_ovf));
        chk("m_cnt_src0",  32'(bus.cnt_src0),    STATS ? 32'(m_c0) : 32'd0);
        chk("m_cnt_src1",  32'(bus.cnt_src1),    STATS ? 32'(m_c1) : 32'd0);
    endtask

    task automatic model_update(input bit v, input bit s, input logic [31:0] d,
                                input bit ordy, input bit fl);
        bit pop;
        bit room;
        if (fl) begin
            model_clear();
            m_flushing = 1'b1;
        end else if (m_flushing) begin
            m_flushing = 1'b0;
        end else begin
            pop  = (mq.size() > 0) && ordy;
            room = (mq.size() < DEPTH) || pop;
            if (pop) void'(mq.pop_front());
            if (v) begin
                if (room) begin
                    mq.push_back({s, d});
                    if (s) m_c1 = (m_c1 < 65535) ? m_c1 + 1 : m_c1;
                    else   m_c0 = (m_c0 < 65535) ? m_c0 + 1 : m_c0;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    endtask

    // One clock: drive at negedge, check current outputs, advance model,
    // return just after the rising edge.
    task automatic step(input bit v, input bit s, input logic [31:0] d,
                        input bit ordy, input bit fl);
        @(negedge clk);
        bus.mstr0_data       = d;
        bus.mstr0_data_valid = {s, v};
        bus.out_ready        = ordy;
        bus.flush            = fl;
        #1;
        check_model();
        model_update(v, s, d, ordy, fl);
        @(posedge clk);
    endtask

    task automatic idle_inputs();
        bus.mstr0_data       = '0;
        bus.mstr0_data_valid = 2'b00;
        bus.out_ready        = 1'b0;
        bus.flush            = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        model_clear();
        rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid),   32'd0);
        chk("rst_out_data",  bus.out_data,         32'd0);
        chk("rst_out_src",   32'(bus.out_src),     32'd0);
        chk("rst_busy",      32'(bus.busy),        32'd0);
        chk("rst_ready",     32'(bus.mstr0_ready), 32'd1);
        chk("rst_overflow",  32'(bus.overflow),    32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // ---- vector table: ordering, full, push+pop at full, overflow, flush
        tbl[0]  = '{1, 0, 32'hA5A5_0001, 1, 0,  1, 32'hA5A5_0001, 0, 1, 1, 0};
        tbl[1]  = '{1, 1, 32'h5A5A_0002, 1, 0,  1, 32'h5A5A_0002, 1, 1, 1, 0};
        tbl[2]  = '{0, 0, 32'h0,         1, 0,  0, 32'h0,         0, 1, 0, 0};
        tbl[3]  = '{1, 0, 32'h1111_0001, 0, 0,  1, 32'h1111_0001, 0, 1, 1, 0};
        tbl[4]  = '{1, 1, 32'h1111_0002, 0, 0,  1, 32'h1111_0001, 0, 1, 1, 0};
        tbl[5]  = '{1, 0, 32'h1111_0003, 0, 0,  1, 32'h1111_0001, 0, 1, 1, 0};
        tbl[6]  = '{1, 1, 32'h1111_0004, 0, 0,  1, 32'h1111_0001, 0, 0, 1, 0};
        tbl[7]  = '{1, 1, 32'hDEAD_BEEF, 1, 0,  1, 32'h1111_0002, 1, 0, 1, 0};
        tbl[8]  = '{1, 0, 32'h1111_0005, 0, 0,  1, 32'h1111_0002, 1, 0, 1, 1};
        tbl[9]  = '{0, 0, 32'h0,         1, 0,  1, 32'h1111_0003, 0, 1, 1, 1};
        tbl[10] = '{1, 0, 32'h7777_7777, 1, 1,  0, 32'h0,         0, 0, 1, 0};
        tbl[11] = '{0, 0, 32'h0,         0, 0,  0, 32'h0,         0, 1, 0, 0};
        tbl[12] = '{1, 1, 32'h1234_5678, 0, 0,  1, 32'h1234_5678, 1, 1, 1, 0};
        tbl[13] = '{0, 0, 32'h0,         1, 0,  0, 32'h0,         0, 1, 0, 0};

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].ordy, tbl[i].fl);
            #1;
            chk($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid),   32'(tbl[i].e_ov));
            chk($sformatf("vec%0d_out_data", i),  bus.out_data,         tbl[i].e_data);
            chk($sformatf("vec%0d_out_src", i),   32'(bus.out_src),     32'(tbl[i].e_src));
            chk($sformatf("vec%0d_ready", i),     32'(bus.mstr0_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("vec%0d_busy", i),      32'(bus.busy),        32'(tbl[i].e_busy));
            chk($sformatf("vec%0d_overflow", i),  32'(bus.overflow),    32'(tbl[i].e_ovf));
        end

        // ---- stats: 3 tag-0 and 2 tag-1 accepted, 1 dropped
        step(0, 0, 32'h0, 0, 1);
        step(0, 0, 32'h0, 0, 0);
        step(1, 0, 32'hC000_0001, 0, 0);
        step(1, 0, 32'hC000_0002, 0, 0);
        step(1, 1, 32'hC000_0003, 0, 0);
        step(1, 1, 32'hC000_0004, 0, 0);
        step(1, 0, 32'hC000_0005, 0, 0);
        step(1, 0, 32'hC000_0006, 1, 0);
        #1;
        chk("stats_cnt_src0", 32'(bus.cnt_src0), STATS ? 32'd3 : 32'd0);
        chk("stats_cnt_src1", 32'(bus.cnt_src1), STATS ? 32'd2 : 32'd0);
        chk("stats_overflow", 32'(bus.overflow), 32'd1);
        chk("stats_head",     bus.out_data,      32'hC000_0002);

        // ---- mid-stream reset with 2 words buffered
        step(0, 0, 32'h0, 0, 1);
        step(0, 0, 32'h0, 0, 0);
        step(1, 0, 32'hB000_0001, 0, 0);
        step(1, 1, 32'hB000_0002, 0, 0);
        @(negedge clk);
        idle_inputs();
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        chk("mrst_out_valid", 32'(bus.out_valid),   32'd0);
        chk("mrst_ready",     32'(bus.mstr0_ready), 32'd1);
        chk("mrst_busy",      32'(bus.busy),        32'd0);
        chk("mrst_cnt_src0",  32'(bus.cnt_src0),    32'd0);
        chk("mrst_cnt_src1",  32'(bus.cnt_src1),    32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 32'h0, 1, 0);
            #1;
            chk("mrst_no_stale", 32'(bus.out_valid), 32'd0);
        end

        // ---- random traffic against the model
        for (int blk = 0; blk < 12; blk++) begin
            int rdy_pct;
            rdy_pct = (blk % 3 == 0) ? 15 : ((blk % 3 == 1) ? 50 : 90);
            for (int i = 0; i < 200; i++) begin
                step(bit'($urandom_range(0, 99) < 70),
                     bit'($urandom_range(0, 1)),
                     32'($urandom),
                     bit'($urandom_range(0, 99) < rdy_pct),
                     bit'($urandom_range(0, 99) < 3));
            end
        end
        step(0, 0, 32'h0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
